// File: rtl/multicycle_control_fsm_if.sv
// Fetch and data-memory request/ack bundle for the multicycle control unit.
// The controller is the master; memories sit on the slave side.
interface multicycle_control_fsm_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] Instr;
    logic                  dmem_req;
    logic                  dmem_we;
    logic                  dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  Instr,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output Instr,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control unit: fetch/decode/execute/mem/wb sequencing
// with req/ack memory handshakes, ack timeout and sticky fault flags.
module multicycle_control_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_fsm_if.master bus,
    input  logic                  Zero,
    output logic [2:0]            ALUControl,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ImmSrc,
    output logic [1:0]            ResultSrc,
    output logic                  RegWrite,
    output logic                  PCWrite,
    output logic                  PCSrc,
    output logic [DATA_WIDTH-1:0] InstrQ,
    output logic                  illegal_instr,
    output logic                  bus_error
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_ADDI,
        OP_SLLI,
        OP_SLL,
        OP_LUI,
        OP_BNE,
        OP_JAL,
        OP_JALR,
        OP_LBU,
        OP_SB,
        OP_BAD
    } op_t;

    state_t        state_q;
    state_t        state_d;
    op_t           op;
    logic [CW-1:0] cnt_q;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = InstrQ[6:0];
    assign f3  = InstrQ[14:12];
    assign f7  = InstrQ[31:25];

    logic is_addi, is_slli, is_sll, is_lui, is_bne;
    logic is_jal, is_jalr, is_lbu, is_sb;

    assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_slli = (opc == 7'b0010011) && (f3 == 3'b001)
                   && (f7 == 7'b0000000);
    assign is_sll  = (opc == 7'b0110011) && (f3 == 3'b001)
                   && (f7 == 7'b0000000);
    assign is_lui  = (opc == 7'b0110111);
    assign is_bne  = (opc == 7'b1100011) && (f3 == 3'b001);
    assign is_jal  = (opc == 7'b1101111);
    assign is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);
    assign is_lbu  = (opc == 7'b0000011) && (f3 == 3'b100);
    assign is_sb   = (opc == 7'b0100011) && (f3 == 3'b000);

    always_comb begin
        op = OP_BAD;
        unique case (1'b1)
            is_addi: op = OP_ADDI;
            is_slli: op = OP_SLLI;
            is_sll:  op = OP_SLL;
            is_lui:  op = OP_LUI;
            is_bne:  op = OP_BNE;
            is_jal:  op = OP_JAL;
            is_jalr: op = OP_JALR;
            is_lbu:  op = OP_LBU;
            is_sb:   op = OP_SB;
            default: op = OP_BAD;
        endcase
    end

    logic wait_st;
    logic ack_now;
    logic timeout;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ack_now = ((state_q == S_FETCH) && bus.imem_ack)
                   || ((state_q == S_MEM) && bus.dmem_ack);
    assign timeout = wait_st && !ack_now
                   && (cnt_q == CW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrQ <= '0;
        end else if ((state_q == S_FETCH) && bus.imem_ack) begin
            InstrQ <= bus.Instr;
        end
    end

    // Any ack or leaving a wait state restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!wait_st || ack_now || timeout) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            if ((state_q == S_DECODE) && (op == OP_BAD)) begin
                illegal_instr <= 1'b1;
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = (op == OP_BAD) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                unique case (op)
                    OP_BNE, OP_JAL, OP_JALR: state_d = S_FETCH;
                    OP_LBU, OP_SB:           state_d = S_MEM;
                    default:                 state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    state_d = (op == OP_SB) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    logic [2:0] alu_ctl;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm_sel;

    always_comb begin
        alu_ctl = 3'b000;
        src_a   = 2'b00;
        src_b   = 2'b01;
        imm_sel = 3'b000;
        unique case (op)
            OP_SLLI: alu_ctl = 3'b111;
            OP_SLL: begin
                alu_ctl = 3'b111;
                src_b   = 2'b00;
            end
            OP_LUI: begin
                alu_ctl = 3'b100;
                src_a   = 2'b10;
                imm_sel = 3'b011;
            end
            OP_BNE: begin
                alu_ctl = 3'b001;
                src_b   = 2'b00;
                imm_sel = 3'b010;
            end
            OP_JAL: begin
                alu_ctl = 3'b010;
                src_a   = 2'b01;
                imm_sel = 3'b100;
            end
            OP_JALR: alu_ctl = 3'b011;
            OP_SB: begin
                alu_ctl = 3'b110;
                imm_sel = 3'b001;
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        ALUControl   = 3'b000;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ImmSrc       = 3'b000;
        ResultSrc    = 2'b00;
        RegWrite     = 1'b0;
        PCWrite      = 1'b0;
        PCSrc        = 1'b0;
        unique case (state_q)
            S_FETCH: bus.imem_req = 1'b1;
            S_EXECUTE: begin
                ALUControl = alu_ctl;
                ALUSrcA    = src_a;
                ALUSrcB    = src_b;
                ImmSrc     = imm_sel;
                unique case (op)
                    OP_BNE: begin
                        PCWrite = 1'b1;
                        PCSrc   = ~Zero;
                    end
                    OP_JAL, OP_JALR: begin
                        PCWrite   = 1'b1;
                        PCSrc     = 1'b1;
                        RegWrite  = 1'b1;
                        ResultSrc = 2'b10;
                    end
                    default: PCWrite = 1'b0;
                endcase
            end
            S_MEM: begin
                ALUControl   = alu_ctl;
                ALUSrcA      = src_a;
                ALUSrcB      = src_b;
                ImmSrc       = imm_sel;
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op == OP_SB);
                // SB retires on the ack cycle itself, no WB slot.
                PCWrite      = (op == OP_SB) && bus.dmem_ack;
            end
            S_WB: begin
                ALUControl = alu_ctl;
                ALUSrcA    = src_a;
                ALUSrcB    = src_b;
                ImmSrc     = imm_sel;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                if (op == OP_LBU) begin
                    ALUControl = 3'b101;
                    ALUSrcB    = 2'b11;
                end
            end
            default: RegWrite = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (WAIT_LIMIT=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_multicycle_control_fsm;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BNE  = 32'h0020_9463;
    localparam logic [31:0] JAL  = 32'h0000_00EF;
    localparam logic [31:0] LBU  = 32'h0000_C183;
    localparam logic [31:0] SB   = 32'h0020_8023;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    logic        clk;
    logic        rst_n;
    logic        Zero;
    logic [2:0]  ALUControl;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        RegWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic [31:0] InstrQ;
    logic        illegal_instr;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;
    int hi;

    multicycle_control_fsm_if #(.DATA_WIDTH(32)) bus ();

    multicycle_control_fsm #(
        .DATA_WIDTH(32),
        .WAIT_LIMIT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .Zero         (Zero),
        .ALUControl   (ALUControl),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ResultSrc    (ResultSrc),
        .RegWrite     (RegWrite),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .InstrQ       (InstrQ),
        .illegal_instr(illegal_instr),
        .bus_error    (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        Zero         = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.Instr    = '0;
        repeat (2) tick();
        check("rst_req", {29'd0, bus.imem_req, bus.dmem_req, bus.dmem_we}, 0);
        check("rst_ctl", {14'd0, ALUControl, ALUSrcA, ALUSrcB, ImmSrc,
                          ResultSrc, RegWrite, PCWrite, PCSrc}, 0);
        check("rst_iq", InstrQ, 0);
        check("rst_flags", {30'd0, illegal_instr, bus_error}, 0);

        bus.Instr    = ADDI;
        bus.imem_ack = 1'b1;
        rst_n        = 1'b1;
        check("idle_req", {31'd0, bus.imem_req}, 0);
        tick();
        check("fetch_c1", {31'd0, bus.imem_req}, 1);
        tick();
        check("dec_iq", InstrQ, ADDI);
        check("dec_req", {31'd0, bus.imem_req}, 0);
        tick();
        check("ex_addi", {22'd0, ALUControl, ALUSrcB, ImmSrc, PCWrite, RegWrite},
              {22'd0, 3'b000, 2'b01, 3'b000, 1'b0, 1'b0});
        tick();
        check("wb_addi", {27'd0, RegWrite, PCWrite, PCSrc, ResultSrc},
              {27'd0, 1'b1, 1'b1, 1'b0, 2'b00});
        tick();
        check("fetch_c5", {31'd0, bus.imem_req}, 1);
        repeat (3) tick();
        check("wb_addi2", {30'd0, RegWrite, PCWrite}, 2'b11);
        tick();

        check("fetch_bne", {31'd0, bus.imem_req}, 1);
        bus.Instr = BNE;
        Zero      = 1'b0;
        repeat (2) tick();
        check("ex_bne_z0", {21'd0, ALUControl, ALUSrcB, ImmSrc,
                            PCWrite, PCSrc, RegWrite},
              {21'd0, 3'b001, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0});
        Zero = 1'b1;
        #1;
        check("ex_bne_z1", {29'd0, PCWrite, PCSrc, RegWrite}, 3'b100);
        tick();
        check("bne_fetch", {30'd0, bus.imem_req, RegWrite}, 2'b10);
        Zero = 1'b0;

        bus.Instr = JAL;
        repeat (2) tick();
        check("ex_jal", {17'd0, ALUControl, ALUSrcA, ALUSrcB, ImmSrc,
                         ResultSrc, RegWrite, PCWrite, PCSrc},
              {17'd0, 3'b010, 2'b01, 2'b01, 3'b100, 2'b10, 1'b1, 1'b1, 1'b1});
        tick();
        check("jal_fetch", {29'd0, bus.imem_req, RegWrite, PCWrite}, 3'b100);

        bus.Instr = LBU;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("ex_lbu", {24'd0, ALUControl, ALUSrcB, ImmSrc},
              {24'd0, 3'b000, 2'b01, 3'b000});
        tick();
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.dmem_req && !bus.dmem_we) hi++;
            if (i == 3) bus.dmem_ack = 1'b1;
            tick();
        end
        bus.dmem_ack = 1'b0;
        check("lbu_req_cyc", hi, 4);
        check("wb_lbu", {22'd0, bus.dmem_req, ALUControl, ALUSrcB, ResultSrc,
                         RegWrite, PCWrite, PCSrc},
              {22'd0, 1'b0, 3'b101, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0});
        tick();

        check("fetch_sb", {31'd0, bus.imem_req}, 1);
        bus.Instr    = SB;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("ex_sb", {24'd0, ALUControl, ALUSrcB, ImmSrc},
              {24'd0, 3'b110, 2'b01, 3'b001});
        tick();
        check("mem_sb", {29'd0, bus.dmem_req, bus.dmem_we, PCWrite}, 3'b110);
        bus.dmem_ack = 1'b1;
        #1;
        check("mem_sb_ack", {29'd0, PCWrite, PCSrc, RegWrite}, 3'b100);
        tick();
        bus.dmem_ack = 1'b0;
        check("sb_fetch", {30'd0, bus.imem_req, bus.dmem_req}, 2'b10);

        bus.Instr    = LBU;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        repeat (2) tick();
        check("mem_lbu2", {31'd0, bus.dmem_req}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem", {29'd0, bus.dmem_req, bus.dmem_we, bus.imem_req}, 0);
        tick();
        rst_n = 1'b1;
        check("rst_idle", {29'd0, bus.imem_req, illegal_instr, bus_error}, 0);
        tick();
        check("rst_fetch", {31'd0, bus.imem_req}, 1);

        bus.Instr    = ADD;
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        check("illegal", {29'd0, illegal_instr, bus_error, bus.imem_req}, 3'b100);
        repeat (3) tick();
        check("trap_hold", {27'd0, illegal_instr, bus.imem_req, bus.dmem_req,
                            RegWrite, PCWrite}, 5'b10000);

        rst_n = 1'b0;
        tick();
        check("rst_clear", {30'd0, illegal_instr, bus_error}, 0);
        rst_n = 1'b1;
        tick();
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.imem_req && !bus_error) hi++;
            tick();
        end
        check("to_req_cyc", hi, 4);
        check("bus_error", {29'd0, bus_error, bus.imem_req, illegal_instr}, 3'b100);
        repeat (2) tick();
        check("be_hold", {30'd0, bus_error, bus.imem_req}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
